duty_level_ctrl: RTL
====================

# duty_level_ctrl

Generates the 4-bit duty-cycle level (0–9) that drives the PWM generator's `duty_level_i`, sitting directly upstream of it. It synchronises and debounces two raw push-button inputs, keeps a saturating target level, and can optionally run an automatic triangle "breathe" ramp. The output level changes only on PWM period boundaries (9-cycle frame), so the PWM stage never sees a mid-period duty change.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a button change is accepted (≥1).
- `STEP_PERIODS`, default 4: PWM periods per breathe step (≥1).

Ports:
- `clk_i`  input  1  clock.
- `rst_i`  input  1  reset; asynchronous, active-high.
- `btn_up_i`  input  1  raw, asynchronous, active-high button input; each accepted press increments the level.
- `btn_dn_i`  input  1  raw, asynchronous, active-high button input; each accepted press decrements the level.
- `mode_i`  input  1  0 = manual, 1 = breathe. Quasi-static; sampled directly.
- `duty_level_o`  output  4  duty level 0..9; connects to the PWM generator's `duty_level_i`.
- `frame_o`  output  1  one-cycle pulse in the cycle where `duty_level_o` is loaded (period end).

## Operation

- **Synchroniser:** 2-FF chain per button, reset to 0.
- **Debounce:** one counter and one `stable` flag per button.
  - While the synchronised value equals `stable`, the counter is held at 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, `stable` takes the synchronised value and the counter clears.
  - A rising edge of `stable` produces a one-cycle press event. Release (falling edge) produces no event.
- **Frame counter:** 0..8, free-running, wraps 8→0. This matches the PWM generator's 9-cycle period; both blocks leave reset together.
  - `period_end` is true when the count equals 8.
- **Target register `tgt`, 0..9, manual mode:**
  - Up event: `tgt` increments, saturating at 9.
  - Down event: `tgt` decrements, saturating at 0.
  - Up and down events in the same cycle: no change.
- **Breathe mode:**
  - Button events are ignored; the debouncers keep running.
  - A step counter counts `period_end` cycles. On the `STEP_PERIODS`-th one it clears and `tgt` moves one step in direction `dir`.
  - `dir` = up: if `tgt` = 9, set `dir` = down and decrement; else increment.
  - `dir` = down: if `tgt` = 0, set `dir` = up and increment; else decrement.
  - Resulting sequence from 0: 0,1,…,9,8,…,0,1,…
- **Mode changes:**
  - Entering breathe: step counter clears; `tgt` keeps its value; `dir` is set to up (down if `tgt` = 9).
  - Leaving breathe: `tgt` is retained.
- **Output:** on `period_end`, `duty_level_o` ← `tgt` and `frame_o` = 1. Otherwise both hold, and `frame_o` = 0.
- **Reset (mid-operation included):** all of the following clear immediately (asynchronous):
  - `duty_level_o` = 0, `frame_o` = 0;
  - `tgt` = 0, `dir` = up;
  - frame, step and debounce counters = 0;
  - synchronisers and `stable` = 0.
  - A button held through reset release is seen as a new press once debounced.

## Timing

- **Button path:** raw rise at edge N appears at the sync output after edge N+2. `stable` rises at edge N+2+`DEBOUNCE_CYCLES`. The press event is high during the following cycle, and `tgt` updates at edge N+3+`DEBOUNCE_CYCLES`.
- **Output latency:** `duty_level_o` reflects `tgt` at the next `period_end` edge, adding 1–9 cycles after the `tgt` update.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles, measured after synchronisation, produces no event.
- **Same-cycle event and step:** a `tgt` update and `period_end` in the same cycle load the old `tgt`; the new value appears one frame later.
- **Breathe rate:** one level step every 9×`STEP_PERIODS` cycles. A full 0→9→0 cycle is 18 steps.

## Configuration

- Macro `DUTY_LEVEL_CTRL_BREATHE_EN`.
- **Defined:** breathe mode, the step counter and `dir` are built as described above.
- **Undefined:** `mode_i` is ignored (unconnected internally); the block is manual-only and the breathe logic is not synthesised. `STEP_PERIODS` is accepted but unused.

## Test plan

- **Reset:** assert `rst_i` asynchronously mid-frame with `tgt` = 5 → `duty_level_o` = 0 and `frame_o` = 0 immediately; after release, first `frame_o` comes 9 cycles later with level 0.
- **Manual up with saturation:** `DEBOUNCE_CYCLES` = 4; 12 clean up presses, each held 10 cycles with 10-cycle gaps → `duty_level_o` steps 1..9 and stays 9; each update is aligned to `frame_o`.
- **Glitch and bounce:** up-input pulses of 1–3 cycles (`DEBOUNCE_CYCLES` = 4) → no change. A bouncing press that settles high for 6 cycles → exactly +1.
- **Simultaneous presses:** `tgt` = 3; up and down asserted on the same edge for 10 cycles → `duty_level_o` remains 3. Down alone at 0 → stays 0.
- **Breathe:** `STEP_PERIODS` = 2 from `tgt` = 7 → levels 8,9,8,7,…,0,1 with a change every 18 cycles. Buttons pressed during breathe have no effect.
- **Mode switch / macro off:** leaving breathe at level 4 → manual holds 4. With the macro undefined, `mode_i` = 1 still behaves as manual.

Source files
------------

// File: rtl/duty_level_ctrl.sv
// Duty-level controller: debounced up/down buttons drive a saturating 0..9 level,
// loaded into duty_level_o only on 9-cycle PWM period ends. Breathe ramp under DUTY_LEVEL_CTRL_BREATHE_EN.
module duty_level_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP_PERIODS    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  input  logic       mode_i,
  output logic [3:0] duty_level_o,
  output logic       frame_o
);

  localparam int unsigned     DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      LVL_MAX    = 4'd9;
  localparam logic [3:0]      FRAME_LAST = 4'd8;

  logic [1:0]      w_btn;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_stable;
  logic [1:0]      r_stable_q;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      w_evt;
  logic            w_up_evt;
  logic            w_dn_evt;

  logic [3:0]      r_frame;
  logic            w_period_end;
  logic [3:0]      r_tgt;
  logic [3:0]      w_tgt_nxt;
  logic [3:0]      w_manual_tgt;

  assign w_btn = {btn_dn_i, btn_up_i};

  // Index 0 = up, 1 = down: 2-FF synchroniser followed by a stability-count debouncer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_q <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_btn;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_evt    = r_stable & ~r_stable_q;
  assign w_up_evt = w_evt[0];
  assign w_dn_evt = w_evt[1];

  // Free-running frame counter mirroring the PWM generator's 9-cycle period
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_frame <= '0;
    end else if (w_period_end) begin
      r_frame <= '0;
    end else begin
      r_frame <= r_frame + 4'd1;
    end
  end

  assign w_period_end = (r_frame == FRAME_LAST);

  always_comb begin
    w_manual_tgt = r_tgt;
    if (w_up_evt && !w_dn_evt && (r_tgt != LVL_MAX)) begin
      w_manual_tgt = r_tgt + 4'd1;
    end else if (w_dn_evt && !w_up_evt && (r_tgt != 4'd0)) begin
      w_manual_tgt = r_tgt - 4'd1;
    end
  end

`ifdef DUTY_LEVEL_CTRL_BREATHE_EN
  localparam int unsigned     STEP_W    = $clog2(STEP_PERIODS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_e;

  dir_e              r_dir;
  dir_e              w_dir_nxt;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;
  logic              r_mode_q;

  // Breathe ramp: triangle walk between 0 and 9, one step per STEP_PERIODS frames
  always_comb begin
    w_tgt_nxt  = r_tgt;
    w_dir_nxt  = r_dir;
    w_step_nxt = r_step;
    if (mode_i && !r_mode_q) begin
      w_step_nxt = '0;
      w_dir_nxt  = (r_tgt == LVL_MAX) ? DIR_DN : DIR_UP;
    end else if (mode_i) begin
      if (w_period_end) begin
        if (r_step == STEP_LAST) begin
          w_step_nxt = '0;
          if (r_dir == DIR_UP) begin
            if (r_tgt == LVL_MAX) begin
              w_dir_nxt = DIR_DN;
              w_tgt_nxt = r_tgt - 4'd1;
            end else begin
              w_tgt_nxt = r_tgt + 4'd1;
            end
          end else begin
            if (r_tgt == 4'd0) begin
              w_dir_nxt = DIR_UP;
              w_tgt_nxt = r_tgt + 4'd1;
            end else begin
              w_tgt_nxt = r_tgt - 4'd1;
            end
          end
        end else begin
          w_step_nxt = r_step + STEP_W'(1);
        end
      end
    end else begin
      w_tgt_nxt = w_manual_tgt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dir    <= DIR_UP;
      r_step   <= '0;
      r_mode_q <= 1'b0;
    end else begin
      r_dir    <= w_dir_nxt;
      r_step   <= w_step_nxt;
      r_mode_q <= mode_i;
    end
  end
`else
  localparam int unsigned unused_step_periods = STEP_PERIODS;
  logic w_unused_mode;
  assign w_unused_mode = mode_i;

  always_comb begin
    w_tgt_nxt = w_manual_tgt;
  end
`endif

  // Target and period-aligned output load; a same-cycle target update is seen next frame
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tgt        <= '0;
      duty_level_o <= '0;
      frame_o      <= 1'b0;
    end else begin
      r_tgt   <= w_tgt_nxt;
      frame_o <= w_period_end;
      if (w_period_end) begin
        duty_level_o <= r_tgt;
      end
    end
  end

endmodule
